// File: rtl/router_fifo_if.sv
// Router output FIFO bus: write side from the register stage/FSM, read side and
// status toward the destination client.
interface router_fifo_if #(
  parameter int DATA_W = 8
);
  logic              write_enb;
  logic              read_enb;
  logic              lfd_state;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              pkt_busy;
  logic              pkt_done;
  logic              ovf;

  modport master (
    output write_enb, read_enb, lfd_state, data_in,
    input  data_out, full, empty, pkt_busy, pkt_done, ovf
  );

  modport slave (
    input  write_enb, read_enb, lfd_state, data_in,
    output data_out, full, empty, pkt_busy, pkt_done, ovf
  );
endinterface

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router with header tagging and read-side
// packet tracking. Optional sticky overflow flag enabled by FIFO_OVF_FLAG_EN.
module router_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         soft_reset,
  router_fifo_if.slave bus
);

  logic [DATA_W:0]   r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [6:0]        r_pkt_cnt;
  logic [DATA_W-1:0] r_data_out;
  logic              r_pkt_done;

  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [DATA_W:0]   w_rd_word;
  logic [6:0]        w_pkt_cnt_nxt;
  logic              w_pkt_done_nxt;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  // A flush wins over any transfer requested in the same cycle.
  assign w_wr_acc  = bus.write_enb && !w_full && !soft_reset;
  assign w_rd_acc  = bus.read_enb && !w_empty && !soft_reset;
  assign w_rd_word = r_mem[r_rd_ptr[ADDR_W-1:0]];

  // Packet length tracking from the tagged word being read.
  always_comb begin
    w_pkt_cnt_nxt  = r_pkt_cnt;
    w_pkt_done_nxt = 1'b0;
    if (w_rd_acc) begin
      if (w_rd_word[DATA_W]) begin
        // Header length field plus the trailing parity byte.
        w_pkt_cnt_nxt = 7'(w_rd_word[DATA_W-1:2]) + 7'd1;
      end else if (r_pkt_cnt != 7'd0) begin
        w_pkt_cnt_nxt  = r_pkt_cnt - 7'd1;
        w_pkt_done_nxt = (r_pkt_cnt == 7'd1);
      end else begin
        w_pkt_cnt_nxt = 7'd0;
      end
    end else begin
      w_pkt_cnt_nxt = r_pkt_cnt;
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= {bus.lfd_state, bus.data_in};
    end
  end

  // Pointers, read data and packet state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pkt_cnt  <= 7'd0;
      r_data_out <= '0;
      r_pkt_done <= 1'b0;
    end else if (soft_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pkt_cnt  <= 7'd0;
      r_data_out <= '0;
      r_pkt_done <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + {{ADDR_W{1'b0}}, 1'b1};
      end
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + {{ADDR_W{1'b0}}, 1'b1};
        r_data_out <= w_rd_word[DATA_W-1:0];
      end
      r_pkt_cnt  <= w_pkt_cnt_nxt;
      r_pkt_done <= w_pkt_done_nxt;
    end
  end

`ifdef FIFO_OVF_FLAG_EN
  logic r_ovf;

  // Sticky overflow: any write attempt while full.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (soft_reset) begin
      r_ovf <= 1'b0;
    end else if (bus.write_enb && w_full) begin
      r_ovf <= 1'b1;
    end
  end

  assign bus.ovf = r_ovf;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.data_out = r_data_out;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.pkt_busy = (r_pkt_cnt != 7'd0);
  assign bus.pkt_done = r_pkt_done;

endmodule
